sc_psr_condition: RTL and testbench
===================================

# sc_psr_condition

Processor-status / condition-code stage sitting directly downstream of the ALU. Captures the ALU's active-low N/Z/V/C flags into a 4-bit PSR when the microcontroller strobes a flag update on a cc-setting operation. Evaluates the 16 SPARC branch conditions against the stored (or same-cycle bypassed) flags and returns a registered taken/not-taken decision to the microsequencer. Also supports direct PSR write and read for PSR transfer microinstructions.

## Interface
- DATAWIDTH_PSR, 4, PSR width, ordered {N,Z,V,C}
- DATAWIDTH_COND, 4, branch condition field width (IR[28:25])
- SC_PSR_CLOCK_50  in  1  system clock, all state on rising edge
- SC_PSR_RESET_InHigh  in  1  synchronous, active-high reset
- SC_PSR_negative_InLow / zero_InLow / overflow_InLow / carry_InLow  in  1 each  ALU flags, active-low
- SC_PSR_setcc_InHigh  in  1  ALU "set condition codes" qualifier
- SC_PSR_load_InHigh  in  1  microcontroller flag-capture strobe
- SC_PSR_write_InHigh  in  1  direct PSR write strobe
- SC_PSR_data_InBUS  in  DATAWIDTH_PSR  direct write value {N,Z,V,C}
- SC_PSR_cond_InBUS  in  DATAWIDTH_COND  branch condition code
- SC_PSR_eval_InHigh  in  1  evaluate-branch request
- SC_PSR_data_OutBUS  out  DATAWIDTH_PSR  stored PSR {N,Z,V,C}, active-high
- SC_PSR_taken_OutHigh  out  1  registered branch decision
- SC_PSR_valid_OutHigh  out  1  one-cycle pulse: taken is fresh

## Operation
- Flags inverted at input; PSR stores active-high.
- Capture enable = load AND setcc. load without setcc: PSR unchanged.
- Next-PSR priority: reset > write (data_InBUS) > capture (ALU flags) > hold.
- Condition (over N,Z,V,C): 0000 never; 0001 Z; 0010 Z|(N^V); 0011 N^V; 0100 C|Z; 0101 C; 0110 N; 0111 V; 1000 always; 1001 ~Z; 1010 ~(Z|(N^V)); 1011 ~(N^V); 1100 ~(C|Z); 1101 ~C; 1110 ~N; 1111 ~V.
- Evaluation source = next-PSR value (bypass): if write or capture occurs in the same cycle as eval, the new flags are used.
- Two-state FSM: IDLE, RESULT. IDLE + eval -> RESULT (latch taken, valid=1). RESULT + eval -> RESULT (back-to-back, new result). RESULT without eval -> IDLE (valid=0). taken holds last value in IDLE.

## Timing
- Reset values: data_OutBUS=4'b0000, taken=0, valid=0, FSM=IDLE.
- PSR update: visible on data_OutBUS one cycle after strobe.
- Branch latency: eval in cycle t -> taken/valid in cycle t+1.
- Reset asserted with eval/load/write same cycle: reset wins, no pulse next cycle.
- Reset mid-RESULT: valid drops next edge.
- Condition field sampled only when eval=1; changes otherwise ignored.

## Structure
- Shared package: condition-code constants (BN..BVC, 4-bit), PSR bit indices (N=3,Z=2,V=1,C=0), FSM state encodings.
- One sub-module natural: sc_cond_eval, purely combinational {psr, cond} -> taken; PSR register and FSM in top.

## Test plan
- Reset: assert reset 2 cycles with all strobes high -> data_OutBUS=0000, taken=0, valid=0.
- Capture: flags_InLow N=0,Z=1,V=1,C=0, setcc=1, load=1 -> next cycle data_OutBUS=1001; same flags with setcc=0 -> unchanged.
- Write priority: write=1 data=0100 with load=setcc=1 and ALU flags all 0 (active) -> PSR=0100.
- Condition sweep: for PSR in {0000,0100,1000,1010,0001}, all 16 conds -> taken matches table (e.g. PSR=1000, cond 0011 -> 1; cond 1011 -> 0).
- Bypass: PSR=0000, same cycle capture Z=1 and eval cond=0001 -> taken=1, valid=1 next cycle.
- Back-to-back: eval three cycles (conds 1000,0000,1000) -> valid high three cycles, taken 1,0,1; then valid=0, taken holds 1.

Source files
------------

// File: rtl/sc_psr_condition_pkg.sv
// Shared definitions for the PSR / condition-code stage: field widths,
// SPARC branch condition encodings, PSR bit positions and FSM states.
package sc_psr_condition_pkg;

  localparam int DATAWIDTH_PSR  = 4;
  localparam int DATAWIDTH_COND = 4;

  // PSR is stored active-high as {N,Z,V,C}
  localparam int PSR_N = 3;
  localparam int PSR_Z = 2;
  localparam int PSR_V = 1;
  localparam int PSR_C = 0;

  localparam logic [DATAWIDTH_COND-1:0] BN   = 4'b0000;
  localparam logic [DATAWIDTH_COND-1:0] BE   = 4'b0001;
  localparam logic [DATAWIDTH_COND-1:0] BLE  = 4'b0010;
  localparam logic [DATAWIDTH_COND-1:0] BL   = 4'b0011;
  localparam logic [DATAWIDTH_COND-1:0] BLEU = 4'b0100;
  localparam logic [DATAWIDTH_COND-1:0] BCS  = 4'b0101;
  localparam logic [DATAWIDTH_COND-1:0] BNEG = 4'b0110;
  localparam logic [DATAWIDTH_COND-1:0] BVS  = 4'b0111;
  localparam logic [DATAWIDTH_COND-1:0] BA   = 4'b1000;
  localparam logic [DATAWIDTH_COND-1:0] BNE  = 4'b1001;
  localparam logic [DATAWIDTH_COND-1:0] BG   = 4'b1010;
  localparam logic [DATAWIDTH_COND-1:0] BGE  = 4'b1011;
  localparam logic [DATAWIDTH_COND-1:0] BGU  = 4'b1100;
  localparam logic [DATAWIDTH_COND-1:0] BCC  = 4'b1101;
  localparam logic [DATAWIDTH_COND-1:0] BPOS = 4'b1110;
  localparam logic [DATAWIDTH_COND-1:0] BVC  = 4'b1111;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RESULT = 1'b1
  } state_t;

endpackage

// File: rtl/sc_psr_condition_cond_eval.sv
// Purely combinational SPARC branch-condition evaluator: {psr, cond} -> taken.
module sc_cond_eval
  import sc_psr_condition_pkg::*;
(
  input  logic [DATAWIDTH_PSR-1:0]  i_psr,
  input  logic [DATAWIDTH_COND-1:0] i_cond,
  output logic                      o_taken
);

  logic w_n;
  logic w_z;
  logic w_v;
  logic w_c;

  assign w_n = i_psr[PSR_N];
  assign w_z = i_psr[PSR_Z];
  assign w_v = i_psr[PSR_V];
  assign w_c = i_psr[PSR_C];

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      BN:      o_taken = 1'b0;
      BE:      o_taken = w_z;
      BLE:     o_taken = w_z | (w_n ^ w_v);
      BL:      o_taken = w_n ^ w_v;
      BLEU:    o_taken = w_c | w_z;
      BCS:     o_taken = w_c;
      BNEG:    o_taken = w_n;
      BVS:     o_taken = w_v;
      BA:      o_taken = 1'b1;
      BNE:     o_taken = ~w_z;
      BG:      o_taken = ~(w_z | (w_n ^ w_v));
      BGE:     o_taken = ~(w_n ^ w_v);
      BGU:     o_taken = ~(w_c | w_z);
      BCC:     o_taken = ~w_c;
      BPOS:    o_taken = ~w_n;
      BVC:     o_taken = ~w_v;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sc_psr_condition.sv
// PSR / condition-code stage: captures ALU flags, supports direct PSR writes,
// and returns a registered branch decision with a one-cycle valid pulse.
module sc_psr_condition
  import sc_psr_condition_pkg::*;
(
  input  logic                      SC_PSR_CLOCK_50,
  input  logic                      SC_PSR_RESET_InHigh,
  input  logic                      SC_PSR_negative_InLow,
  input  logic                      SC_PSR_zero_InLow,
  input  logic                      SC_PSR_overflow_InLow,
  input  logic                      SC_PSR_carry_InLow,
  input  logic                      SC_PSR_setcc_InHigh,
  input  logic                      SC_PSR_load_InHigh,
  input  logic                      SC_PSR_write_InHigh,
  input  logic [DATAWIDTH_PSR-1:0]  SC_PSR_data_InBUS,
  input  logic [DATAWIDTH_COND-1:0] SC_PSR_cond_InBUS,
  input  logic                      SC_PSR_eval_InHigh,
  output logic [DATAWIDTH_PSR-1:0]  SC_PSR_data_OutBUS,
  output logic                      SC_PSR_taken_OutHigh,
  output logic                      SC_PSR_valid_OutHigh
);

  logic [DATAWIDTH_PSR-1:0] r_psr;
  logic [DATAWIDTH_PSR-1:0] w_psrNext;
  logic [DATAWIDTH_PSR-1:0] w_aluFlags;
  logic                     w_capture;
  logic                     w_condTaken;
  logic                     r_taken;
  state_t                   r_state;
  state_t                   w_stateNext;

  assign w_aluFlags = ~{SC_PSR_negative_InLow, SC_PSR_zero_InLow,
                        SC_PSR_overflow_InLow, SC_PSR_carry_InLow};
  assign w_capture  = SC_PSR_load_InHigh & SC_PSR_setcc_InHigh;

  // Direct write beats flag capture; reset is applied in the register below
  always_comb begin
    w_psrNext = r_psr;
    if (SC_PSR_write_InHigh) begin
      w_psrNext = SC_PSR_data_InBUS;
    end else if (w_capture) begin
      w_psrNext = w_aluFlags;
    end
  end

  // Branches see same-cycle flag updates by evaluating the next-PSR value
  sc_cond_eval u_condEval (
    .i_psr   (w_psrNext),
    .i_cond  (SC_PSR_cond_InBUS),
    .o_taken (w_condTaken)
  );

  always_ff @(posedge SC_PSR_CLOCK_50) begin
    if (SC_PSR_RESET_InHigh) begin
      r_psr <= '0;
    end else begin
      r_psr <= w_psrNext;
    end
  end

  always_ff @(posedge SC_PSR_CLOCK_50) begin
    if (SC_PSR_RESET_InHigh) begin
      r_taken <= 1'b0;
    end else if (SC_PSR_eval_InHigh) begin
      r_taken <= w_condTaken;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:   if (SC_PSR_eval_InHigh) w_stateNext = ST_RESULT;
      ST_RESULT: if (!SC_PSR_eval_InHigh) w_stateNext = ST_IDLE;
      default:   w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge SC_PSR_CLOCK_50) begin
    if (SC_PSR_RESET_InHigh) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  assign SC_PSR_data_OutBUS   = r_psr;
  assign SC_PSR_taken_OutHigh = r_taken;
  assign SC_PSR_valid_OutHigh = (r_state == ST_RESULT);

endmodule

// File: tb/tb_sc_psr_condition.sv
// Self-checking bench for sc_psr_condition: directed scenarios plus a
// randomized run, all checked against a behavioural flag/branch model.
module tb_sc_psr_condition;

  logic       clock;
  logic       resetIn;
  logic [3:0] flagsLow;
  logic       setcc;
  logic       load;
  logic       writeEn;
  logic [3:0] dataIn;
  logic [3:0] condIn;
  logic       evalIn;
  logic [3:0] dataOut;
  logic       takenOut;
  logic       validOut;

  int compared;
  int mismatched;

  logic [3:0] modelPsr;
  logic       modelTaken;
  logic       modelValid;

  sc_psr_condition dut (
    .SC_PSR_CLOCK_50       (clock),
    .SC_PSR_RESET_InHigh   (resetIn),
    .SC_PSR_negative_InLow (flagsLow[3]),
    .SC_PSR_zero_InLow     (flagsLow[2]),
    .SC_PSR_overflow_InLow (flagsLow[1]),
    .SC_PSR_carry_InLow    (flagsLow[0]),
    .SC_PSR_setcc_InHigh   (setcc),
    .SC_PSR_load_InHigh    (load),
    .SC_PSR_write_InHigh   (writeEn),
    .SC_PSR_data_InBUS     (dataIn),
    .SC_PSR_cond_InBUS     (condIn),
    .SC_PSR_eval_InHigh    (evalIn),
    .SC_PSR_data_OutBUS    (dataOut),
    .SC_PSR_taken_OutHigh  (takenOut),
    .SC_PSR_valid_OutHigh  (validOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Branch rule: low three bits pick a base test, top bit inverts it
  function automatic logic condModel(input logic [3:0] psr, input logic [3:0] c);
    logic n, z, v, cy, base;
    n = psr[3]; z = psr[2]; v = psr[1]; cy = psr[0];
    case (c[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z | (n ^ v);
      3'd3: base = n ^ v;
      3'd4: base = cy | z;
      3'd5: base = cy;
      3'd6: base = n;
      default: base = v;
    endcase
    return c[3] ? ~base : base;
  endfunction

  // Drive one cycle of inputs, advance the model, then clock the DUT
  task automatic applyStimulus(input logic rst, input logic ld, input logic sc,
                               input logic [3:0] fl, input logic wr,
                               input logic [3:0] d, input logic ev,
                               input logic [3:0] c);
    logic [3:0] nextPsr;
    resetIn = rst; load = ld; setcc = sc; flagsLow = fl;
    writeEn = wr; dataIn = d; evalIn = ev; condIn = c;
    if (rst) begin
      modelPsr = 4'b0000; modelTaken = 1'b0; modelValid = 1'b0;
    end else begin
      nextPsr = wr ? d : ((ld && sc) ? ~fl : modelPsr);
      if (ev) modelTaken = condModel(nextPsr, c);
      modelValid = ev;
      modelPsr = nextPsr;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b1111, 1'b1, 4'b1000);
      compared++;
      if (dataOut !== 4'b0000) begin
        $display("[TB] FAIL reset_psr cycle %0d got %b want 0000", i, dataOut); mismatched++;
      end
      compared++;
      if (takenOut !== 1'b0) begin
        $display("[TB] FAIL reset_taken cycle %0d got %b want 0", i, takenOut); mismatched++;
      end
      compared++;
      if (validOut !== 1'b0) begin
        $display("[TB] FAIL reset_valid cycle %0d got %b want 0", i, validOut); mismatched++;
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000);
    compared++;
    if (validOut !== 1'b0) begin
      $display("[TB] FAIL reset_no_pulse got %b want 0", validOut); mismatched++;
    end
  endtask

  task automatic test_capture();
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 4'b0000, 1'b0, 4'b0000);
    compared++;
    if (dataOut !== 4'b1001) begin
      $display("[TB] FAIL capture got %b want 1001", dataOut); mismatched++;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
    compared++;
    if (dataOut !== 4'b1001) begin
      $display("[TB] FAIL capture_no_setcc got %b want 1001", dataOut); mismatched++;
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
    compared++;
    if (dataOut !== 4'b1001) begin
      $display("[TB] FAIL capture_no_load got %b want 1001", dataOut); mismatched++;
    end
  endtask

  task automatic test_write_priority();
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0000);
    compared++;
    if (dataOut !== 4'b0100) begin
      $display("[TB] FAIL write_priority got %b want 0100", dataOut); mismatched++;
    end
  endtask

  task automatic test_cond_sweep();
    logic [3:0] psrList [5] = '{4'b0000, 4'b0100, 4'b1000, 4'b1010, 4'b0001};
    for (int p = 0; p < 5; p++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, psrList[p], 1'b0, 4'b0000);
      for (int c = 0; c < 16; c++) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'(c));
        compared++;
        if (takenOut !== modelTaken || validOut !== 1'b1) begin
          $display("[TB] FAIL cond_sweep psr=%b cond=%0d got taken=%b valid=%b want taken=%b valid=1",
                   psrList[p], c, takenOut, validOut, modelTaken);
          mismatched++;
        end
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'b0011);
    compared++;
    if (takenOut !== 1'b1) begin
      $display("[TB] FAIL cond_bl_n_set got %b want 1", takenOut); mismatched++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'b1011);
    compared++;
    if (takenOut !== 1'b0) begin
      $display("[TB] FAIL cond_bge_n_set got %b want 0", takenOut); mismatched++;
    end
  endtask

  task automatic test_bypass();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 4'b0000, 1'b1, 4'b0001);
    compared++;
    if (takenOut !== 1'b1 || validOut !== 1'b1) begin
      $display("[TB] FAIL bypass got taken=%b valid=%b want taken=1 valid=1", takenOut, validOut);
      mismatched++;
    end
    compared++;
    if (dataOut !== 4'b0100) begin
      $display("[TB] FAIL bypass_psr got %b want 0100", dataOut); mismatched++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] conds [3]     = '{4'b1000, 4'b0000, 4'b1000};
    logic       wantTaken [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, conds[i]);
      compared++;
      if (takenOut !== wantTaken[i] || validOut !== 1'b1) begin
        $display("[TB] FAIL back_to_back step %0d got taken=%b valid=%b want taken=%b valid=1",
                 i, takenOut, validOut, wantTaken[i]);
        mismatched++;
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000);
    compared++;
    if (takenOut !== 1'b1 || validOut !== 1'b0) begin
      $display("[TB] FAIL back_to_back_idle got taken=%b valid=%b want taken=1 valid=0", takenOut, validOut);
      mismatched++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000);
    compared++;
    if (takenOut !== 1'b1) begin
      $display("[TB] FAIL cond_ignored_no_eval got taken=%b want 1", takenOut); mismatched++;
    end
  endtask

  task automatic test_reset_mid_result();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'b1000);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'b1000);
    compared++;
    if (validOut !== 1'b0 || takenOut !== 1'b0) begin
      $display("[TB] FAIL reset_mid_result got taken=%b valid=%b want taken=0 valid=0", takenOut, validOut);
      mismatched++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
                    4'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom),
                    1'($urandom), 4'($urandom));
      compared++;
      if (dataOut !== modelPsr || takenOut !== modelTaken || validOut !== modelValid) begin
        $display("[TB] FAIL random cycle %0d got psr=%b taken=%b valid=%b want psr=%b taken=%b valid=%b",
                 i, dataOut, takenOut, validOut, modelPsr, modelTaken, modelValid);
        mismatched++;
      end
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    resetIn = 1'b1; load = 1'b0; setcc = 1'b0; flagsLow = 4'b1111;
    writeEn = 1'b0; dataIn = 4'b0000; evalIn = 1'b0; condIn = 4'b0000;
    test_reset();
    test_capture();
    test_write_priority();
    test_cond_sweep();
    test_bypass();
    test_back_to_back();
    test_reset_mid_result();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
